// File: rtl/button_event.sv
// button_event: turns the debounced (asynchronous) button level into clk-domain
// event strobes: press, release, long-press and auto-repeat, plus a held flag
// and a wrapping press counter.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset (release assumed synchronized upstream)
//   in           debounced button level, 1 = pressed, asynchronous to clk
//   press        1-cycle strobe on press
//   rel          1-cycle strobe on release (named rel: 'release' is a keyword)
//   long_press   1-cycle strobe when the hold reaches LONG_CYCLES
//   rpt          1-cycle auto-repeat strobe (named rpt: 'repeat' is a keyword)
//   held         synchronized level, high while the button is held
//   press_count  presses since reset, wraps
module button_event #(
  parameter int unsigned LONG_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000,
  parameter bit          REPEAT_EN     = 1'b1,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in,
  output logic             press,
  output logic             rel,
  output logic             long_press,
  output logic             rpt,
  output logic             held,
  output logic [CNT_W-1:0] press_count
);

  localparam int unsigned CNT_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int unsigned HC_W    = $clog2(CNT_MAX);
  localparam logic [HC_W-1:0] LONG_LAST = HC_W'(LONG_CYCLES - 1);
  localparam logic [HC_W-1:0] REP_LAST  = HC_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_LONG = 2'd2
  } state_e;

  logic             sync1_q, sync2_q, prev_q;
  logic             sync1_d, sync2_d, prev_d;
  state_e           state_q, state_d;
  logic [HC_W-1:0]  cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;
  logic             long_q, long_d;
  logic             rpt_q, rpt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             rise, fall;

  // Two-flop synchronizer plus the previous-level flop for edge detection.
  always_comb begin
    sync1_d = in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign rise = sync2_q & ~prev_q;
  assign fall = ~sync2_q & prev_q;

  // State register with hold counter, strobes and press counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
      rpt_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
      rpt_q   <= rpt_d;
      count_q <= count_d;
    end
  end

  // Next state and strobes; a fall always wins over a coincident counter expiry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    long_d  = 1'b0;
    rpt_d   = 1'b0;
    count_d = count_q;
    unique case (state_q)
      ST_IDLE: begin
        if (rise) begin
          press_d = 1'b1;
          count_d = count_q + CNT_W'(1);
          cnt_d   = '0;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (fall) begin
          rel_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_q == LONG_LAST) begin
          long_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_LONG;
        end else begin
          cnt_d = cnt_q + HC_W'(1);
        end
      end
      ST_LONG: begin
        if (fall) begin
          rel_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (REPEAT_EN) begin
          if (cnt_q == REP_LAST) begin
            rpt_d = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + HC_W'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign press       = press_q;
  assign rel         = rel_q;
  assign long_press  = long_q;
  assign rpt         = rpt_q;
  assign held        = sync2_q;
  assign press_count = count_q;

endmodule

// File: tb/tb_button_event.sv
// Scoreboard bench for button_event: two instances (auto-repeat on/off) share
// one randomized button waveform. Each hold of D cycles starting at edge r is
// turned into its expected events directly: press at r+2, long_press at r+2+L
// if D > L, repeats every R after that while before the release at r+D+2.
module tb_button_event;

  localparam int unsigned L   = 10;
  localparam int unsigned R   = 4;
  localparam int          INF = 32'h7fff_ffff;

  localparam int K_PRESS = 0;
  localparam int K_REL   = 1;
  localparam int K_LONG  = 2;
  localparam int K_RPT   = 3;

  typedef struct {
    int         cyc;
    int         kind;
    logic [7:0] cnt;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in = 1'b0;
  logic       p0, r0, l0, t0, h0;
  logic       p1, r1, l1, t1, h1;
  logic [7:0] c0, c1;

  ev_t        q0[$];
  ev_t        q1[$];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] pcount = 8'd0;
  logic       samp = 1'b0;
  logic       held_exp = 1'b0;

  button_event #(.LONG_CYCLES(L), .REPEAT_CYCLES(R), .REPEAT_EN(1'b1), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .press(p0), .rel(r0), .long_press(l0),
    .rpt(t0), .held(h0), .press_count(c0));

  button_event #(.LONG_CYCLES(L), .REPEAT_CYCLES(R), .REPEAT_EN(1'b0), .CNT_W(8)) dut_nr (
    .clk(clk), .rst_n(rst_n), .in(in), .press(p1), .rel(r1), .long_press(l1),
    .rpt(t1), .held(h1), .press_count(c1));

  always #5 clk = ~clk;

  // Edge counter and the expected held level (input as seen two edges back).
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    held_exp <= samp;
    samp     <= rst_n ? in : 1'b0;
  end

  function automatic void push(int id, int t, int k, logic [7:0] c, int cut);
    ev_t e;
    if (t < cut) begin
      e.cyc = t; e.kind = k; e.cnt = c;
      if (id == 0) q0.push_back(e);
      else         q1.push_back(e);
    end
  endfunction

  // Expected events for a hold starting at edge r lasting d cycles; events at or
  // after edge 'cut' are lost to a reset.
  function automatic void emit(int r, int d, int cut);
    int rl = r + d + 2;
    int tl = r + 2 + int'(L);
    pcount = pcount + 8'd1;
    push(0, r + 2, K_PRESS, pcount, cut);
    push(1, r + 2, K_PRESS, pcount, cut);
    if (d > int'(L)) begin
      push(0, tl, K_LONG, 8'd0, cut);
      push(1, tl, K_LONG, 8'd0, cut);
      for (int t = tl + int'(R); t < rl; t += int'(R)) push(0, t, K_RPT, 8'd0, cut);
    end
    push(0, rl, K_REL, 8'd0, cut);
    push(1, rl, K_REL, 8'd0, cut);
  endfunction

  function automatic int qsize(int id);
    return (id == 0) ? q0.size() : q1.size();
  endfunction

  function automatic ev_t qpop(int id);
    if (id == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  function automatic int qfront_cyc(int id);
    return (id == 0) ? q0[0].cyc : q1[0].cyc;
  endfunction

  task automatic check_dut(int id, logic p, logic r, logic l, logic t, logic h, logic [7:0] c);
    ev_t e;
    int  nstr;
    int  k;
    nstr = int'(p) + int'(r) + int'(l) + int'(t);
    while (qsize(id) > 0 && qfront_cyc(id) < cyc) begin
      e = qpop(id);
      n_cmp++; n_bad++;
      $display("FAIL missed_event dut%0d: no strobe at cyc %0d, required kind %0d", id, e.cyc, e.kind);
    end
    n_cmp++;
    if (h !== held_exp) begin
      n_bad++;
      $display("FAIL held dut%0d cyc %0d: got %b required %b", id, cyc, h, held_exp);
    end
    if (nstr > 1) begin
      n_cmp++; n_bad++;
      $display("FAIL one_hot dut%0d cyc %0d: got %0d strobes required at most 1", id, cyc, nstr);
    end
    if (nstr >= 1) begin
      k = p ? K_PRESS : (r ? K_REL : (l ? K_LONG : K_RPT));
      n_cmp++;
      if (qsize(id) == 0) begin
        n_bad++;
        $display("FAIL unexpected_strobe dut%0d cyc %0d: got kind %0d required none", id, cyc, k);
      end else begin
        e = qpop(id);
        if (e.cyc != cyc || e.kind != k) begin
          n_bad++;
          $display("FAIL event dut%0d: got kind %0d at cyc %0d required kind %0d at cyc %0d",
                   id, k, cyc, e.kind, e.cyc);
        end else if (k == K_PRESS && c !== e.cnt) begin
          n_bad++;
          $display("FAIL press_count dut%0d cyc %0d: got %0d required %0d", id, cyc, c, e.cnt);
        end
      end
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (cyc > 0) begin
      if (!rst_n) begin
        n_cmp++;
        if ({p0, r0, l0, t0, h0, c0, p1, r1, l1, t1, h1, c1} !== '0) begin
          n_bad++;
          $display("FAIL reset_outputs cyc %0d: got %b/%b required all zero", cyc,
                   {p0, r0, l0, t0, h0, c0}, {p1, r1, l1, t1, h1, c1});
        end
      end else begin
        check_dut(0, p0, r0, l0, t0, h0, c0);
        check_dut(1, p1, r1, l1, t1, h1, c1);
      end
    end
  end

  // Drive 'lvl' for n sampling edges (always alternates with the previous level).
  task automatic seg(logic lvl, int n);
    if (lvl) emit(cyc + 1, n, INF);
    in = lvl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reset asserted k edges into a hold; in stays high through and after reset.
  task automatic hold_reset(int k, int rlen, int d2);
    emit(cyc + 1, 1000, cyc + k);
    in = 1'b1;
    repeat (k) @(posedge clk);
    #1 rst_n = 1'b0;
    pcount = 8'd0;
    repeat (rlen) @(posedge clk);
    #1 rst_n = 1'b1;
    emit(cyc + 1, d2, INF);
    repeat (d2) @(posedge clk);
    #1 in = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
    $fatal(1);
  end

  initial begin
    // Reset with the input toggling.
    repeat (5) begin
      @(posedge clk);
      #1 in = ~in;
    end
    in = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    seg(1'b0, 3);

    // Short press, long hold with repeats, release at or near expiry boundaries.
    seg(1'b1, 5);  seg(1'b0, 8);
    seg(1'b1, 30); seg(1'b0, 8);
    seg(1'b1, 9);  seg(1'b0, 6);
    seg(1'b1, 10); seg(1'b0, 6);
    seg(1'b1, 11); seg(1'b0, 6);
    seg(1'b1, 14); seg(1'b0, 6);
    seg(1'b1, 15); seg(1'b0, 6);

    // Enough short presses to wrap press_count.
    for (int i = 0; i < 256; i++) begin
      seg(1'b1, int'($urandom_range(1, 3)));
      seg(1'b0, int'($urandom_range(1, 3)));
    end

    // Reset in the middle of a hold, button still down afterwards.
    hold_reset(6, 3, 12);
    seg(1'b0, 8);

    // Random holds and gaps.
    for (int i = 0; i < 80; i++) begin
      seg(1'b1, int'($urandom_range(1, 35)));
      seg(1'b0, int'($urandom_range(1, 12)));
    end
    seg(1'b0, 10);

    n_cmp++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_bad++;
      $display("FAIL leftover_events: got %0d/%0d pending required 0/0", q0.size(), q1.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/button_event.md
Name: button_event

Overview:
- Consumes the debounced level `in` from the switch debouncer, which is driven from a divided clock and is therefore treated as asynchronous.
- Converts that level into single-cycle event strobes in the `clk` domain: press, release, long-press and auto-repeat.
- Also provides a held flag and a wrapping press counter.
- Sits between the switch debouncer and application FSMs (counters, menu logic, 7-seg controllers).

Parameters:
LONG_CYCLES, 50_000_000, clk cycles of continuous hold before long_press fires; must be >= 2
REPEAT_CYCLES, 10_000_000, clk cycles between successive repeat strobes after long_press; must be >= 2
REPEAT_EN, 1, 1 = auto-repeat enabled; 0 = stay in LONG state silently after long_press
CNT_W, 8, width of press_count

Ports:
clk  input  1  system clock; all logic rising-edge
rst_n  input  1  asynchronous active-low reset
in  input  1  debounced button level from the debouncer, 1 = pressed; asynchronous to clk
press  output  1  one-cycle strobe on press
release  output  1  one-cycle strobe on release
long_press  output  1  one-cycle strobe when hold reaches LONG_CYCLES
repeat  output  1  one-cycle strobe every REPEAT_CYCLES after long_press
held  output  1  synchronized level, high while button is held
press_count  output  CNT_W  number of presses since reset, wraps

Behaviour:
- Reset: the async assert of rst_n clears everything.
  - Cleared state: sync flops, prev flop, FSM = IDLE, hold counter = 0, press_count = 0.
  - All outputs are 0 while rst_n is low and on the first edge after release of reset.
  - Deassertion is not synchronized here; the top level provides a synchronized release.
- Synchronizer: two flops, sync1 <= in, sync2 <= sync1; held = sync2; prev <= sync2.
- Edge detection: rise = sync2 & ~prev; fall = ~sync2 & prev.
- All strobes are registered outputs.
  - Latency from in changing (setup met) to strobe high is 3 rising edges.
  - Each strobe is high for exactly 1 cycle.
- FSM states: IDLE, HOLD, LONG.
  - IDLE: on rise -> press=1, press_count += 1 (wraps 2^CNT_W-1 -> 0), cnt = 0, go HOLD.
  - HOLD: on fall -> release=1, go IDLE.
    - Otherwise cnt increments each cycle.
    - When cnt == LONG_CYCLES-1 -> long_press=1, cnt = 0, go LONG.
  - LONG: on fall -> release=1, go IDLE.
    - Else if REPEAT_EN: cnt increments; at cnt == REPEAT_CYCLES-1 -> repeat=1, cnt = 0.
    - Else if !REPEAT_EN: cnt is held at 0.
- Timing of long_press: it fires exactly LONG_CYCLES cycles after the press strobe.
- Timing of repeat: the first repeat fires REPEAT_CYCLES cycles after long_press, then periodically with the same spacing.
- Priority: fall beats a simultaneous counter expiry. Release fires; long_press/repeat do not fire in that cycle.
- At most one of press/release/long_press/repeat is high in any cycle.
- Hold counter: cnt width is clog2(max(LONG_CYCLES, REPEAT_CYCLES)); it never exceeds its terminal value.
- A glitch on `in` shorter than one clk period may be missed or may produce a matched press/release pair; both outcomes are legal.
- Press/release pairing:
  - A press is never emitted without a later release, unless reset intervenes.
  - Release is only emitted from HOLD or LONG.
- Reset mid-hold: all state clears and no release is emitted.
  - If `in` is still high after reset, a fresh press is emitted 3 edges after rst_n deasserts.
- `in` high during reset: this is treated as a new press after reset.

Test Plan (LONG_CYCLES=10, REPEAT_CYCLES=4, CNT_W=8 unless noted):
1. Reset:
   - Stimulus: hold rst_n=0 for 5 cycles with in toggling.
   - Response: all outputs 0, press_count=0; no strobes during reset.
2. Short press:
   - Stimulus: in=1 for 5 cycles, then in=0.
   - Response: press at edge 3 after the rise; release 3 edges after the fall; no long_press; press_count=1; held high for 5 cycles.
3. Long hold with repeat:
   - Stimulus: in=1 for 30 cycles.
   - Response: press at t; long_press at t+10; repeat at t+14, t+18, t+22, t+26, t+30 (only those before the fall lands); then exactly one release.
4. Release coincident with expiry:
   - Stimulus: time the fall so it reaches sync2 on the cycle long_press would fire (t+10).
   - Response: release=1, long_press stays 0, FSM back to IDLE.
5. REPEAT_EN=0:
   - Stimulus: 30-cycle hold.
   - Response: a single long_press at t+10; no repeat strobes; release at the end.
6. Counter wrap and reset mid-hold:
   - Stimulus: 256 short presses, then assert rst_n mid-hold.
   - Response: press_count goes 255 -> 0; after the reset there is no release, and a new press fires 3 edges after rst_n deasserts with in still 1.
